seg_scan_mux: RTL and testbench

Time-multiplexing scanner for the 4-digit common-anode 7-segment display. It latches a 16-bit hex value and cycles through the four digits. For each digit it drives a one-hot active-low anode pattern on `seg_an` and presents that digit's nibble to the single-digit hex-to-cathode decoder directly downstream, whose `sw` input it feeds. It adds a blanking gap between digits to suppress ghosting, optional leading-zero blanking, and tear-free value updates at frame boundaries.

---
 rtl/seg_pkg.sv | 9 +
 rtl/seg_scan_timer.sv | 29 ++
 rtl/seg_scan_mux.sv | 53 +++++
 tb/tb_seg_scan_mux.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, digit index type and anode helper for the 7-segment scanner
package seg_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [3:0] ANODE_OFF = 4'b1111;
  typedef logic [$clog2(NUM_DIGITS)-1:0] digit_t;
  function automatic logic [3:0] anode_on(digit_t idx);
    return ~(4'b0001 << idx);
  endfunction
endpackage

// File: rtl/seg_scan_timer.sv
// seg_scan_timer: slot counter and digit index; flags the blank phase and the first clock of each slot
module seg_scan_timer
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic   clk,
  input  logic   rst_n,
  output digit_t digit_idx,
  output logic   in_blank,
  output logic   slot_start
);
  localparam int CW = $clog2(REFRESH_DIV);
  logic [CW-1:0] cnt;
  logic wrap;
  assign wrap       = cnt == CW'(REFRESH_DIV - 1);
  assign in_blank   = cnt < CW'(BLANK_CYCLES);
  assign slot_start = cnt == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      digit_idx <= '0;
    end else begin
      cnt <= wrap ? '0 : cnt + CW'(1);
      if (wrap) digit_idx <= digit_idx + digit_t'(1);
    end
  end
endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: 4-digit common-anode scanner with blanking gap, leading-zero blanking
// and frame-aligned value updates; all outputs registered
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        value_valid,
  input  logic [3:0]  digit_en,
  input  logic        lzb_en,
  output logic [3:0]  nibble,
  output logic [3:0]  seg_an,
  output logic [1:0]  digit_idx,
  output logic        frame_start
);
  digit_t      t_idx;
  logic        in_blank, slot_start, pend_flag, commit, frame_edge, lead_zero, suppress;
  logic [15:0] pending, shown, next_shown;
  seg_scan_timer #(.REFRESH_DIV(REFRESH_DIV), .BLANK_CYCLES(BLANK_CYCLES)) u_timer (
    .clk(clk), .rst_n(rst_n), .digit_idx(t_idx), .in_blank(in_blank), .slot_start(slot_start)
  );
  // the committed value is used on the same edge so the first frame cycle already shows it
  always_comb begin
    frame_edge = slot_start && t_idx == '0;
    commit     = frame_edge && pend_flag;
    next_shown = commit ? pending : shown;
    lead_zero  = (t_idx != '0) && ((next_shown >> {t_idx, 2'b00}) == '0);
    suppress   = !digit_en[t_idx] || (lzb_en && lead_zero);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= '0;
      shown       <= '0;
      pend_flag   <= 1'b0;
      seg_an      <= ANODE_OFF;
      nibble      <= '0;
      digit_idx   <= '0;
      frame_start <= 1'b0;
    end else begin
      if (value_valid) pending <= value;
      pend_flag   <= value_valid || (pend_flag && !commit);
      shown       <= next_shown;
      seg_an      <= (in_blank || suppress) ? ANODE_OFF : anode_on(t_idx);
      nibble      <= next_shown[{t_idx, 2'b00} +: 4];
      digit_idx   <= t_idx;
      frame_start <= frame_edge;
    end
  end
endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: directed tests of the scanner with REFRESH_DIV=8, BLANK_CYCLES=2 (32-clock frame)
module tb_seg_scan_mux;
  logic        clk = 0, rst_n = 0, value_valid = 0, lzb_en = 0;
  logic [15:0] value = 0;
  logic [3:0]  digit_en = 4'hF, nibble, seg_an;
  logic [1:0]  digit_idx;
  logic        frame_start;
  int checks = 0, failures = 0;
  logic [3:0] an_q [33], nib_q [33];
  logic [1:0] idx_q [33];
  logic       fs_q [33];

  seg_scan_mux #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .value_valid(value_valid), .digit_en(digit_en),
    .lzb_en(lzb_en), .nibble(nibble), .seg_an(seg_an), .digit_idx(digit_idx), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    checks++;
    if (!(seg_an inside {4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1111})) begin
      failures++;
      $display("FAIL legal_anode t=%0t seg_an=%b not a legal pattern", $time, seg_an);
    end
  end

  function automatic logic [3:0] exp_an(int c, logic [3:0] supp);
    int s = c / 8;
    return (c % 8 < 2 || supp[s]) ? 4'b1111 : ~(4'b0001 << s);
  endfunction

  function automatic logic [3:0] exp_nib(int c, logic [15:0] v);
    return v[(c / 8) * 4 +: 4];
  endfunction

  task automatic strobe(input logic [15:0] v);
    value = v;
    value_valid = 1;
    @(negedge clk);
    value_valid = 0;
  endtask

  task automatic wait_fs(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 40);
    checks++;
    if (!frame_start) begin
      failures++;
      $display("FAIL %s_wait_fs no frame_start within 40 cycles", tag);
    end
  endtask

  task automatic capture();
    for (int c = 0; c < 33; c++) begin
      if (c > 0) @(negedge clk);
      an_q[c] = seg_an; nib_q[c] = nibble; idx_q[c] = digit_idx; fs_q[c] = frame_start;
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (seg_an !== 4'hF || nibble !== 4'h0 || digit_idx !== 2'd0 || frame_start !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs an=%b nib=%h idx=%0d fs=%b want 1111/0/0/0", seg_an, nibble, digit_idx, frame_start);
    end
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b1 || seg_an !== 4'hF || digit_idx !== 2'd0) begin
      failures++;
      $display("FAIL reset_first_edge fs=%b an=%b idx=%0d want 1/1111/0", frame_start, seg_an, digit_idx);
    end
  endtask

  task automatic test_basic();
    strobe(16'h1234);
    wait_fs("basic");
    capture();
    for (int c = 0; c < 32; c++) begin
      checks++;
      if (an_q[c] !== exp_an(c, 4'b0000) || nib_q[c] !== exp_nib(c, 16'h1234) || idx_q[c] !== 2'(c / 8) || fs_q[c] !== (c == 0)) begin
        failures++;
        $display("FAIL basic c=%0d an=%b/%b nib=%h/%h idx=%0d fs=%b", c, an_q[c], exp_an(c, 4'b0000), nib_q[c], exp_nib(c, 16'h1234), idx_q[c], fs_q[c]);
      end
    end
    checks++;
    if (fs_q[32] !== 1'b1) begin
      failures++;
      $display("FAIL basic_period frame_start at +32 = %b want 1", fs_q[32]);
    end
  endtask

  task automatic test_lzb_00a0();
    lzb_en = 1;
    strobe(16'h00A0);
    wait_fs("lzb_00a0");
    capture();
    for (int c = 0; c < 32; c++) begin
      checks++;
      if (an_q[c] !== exp_an(c, 4'b1100) || nib_q[c] !== exp_nib(c, 16'h00A0)) begin
        failures++;
        $display("FAIL lzb_00a0 c=%0d an=%b/%b nib=%h/%h", c, an_q[c], exp_an(c, 4'b1100), nib_q[c], exp_nib(c, 16'h00A0));
      end
    end
  endtask

  task automatic test_lzb_zero();
    strobe(16'h0000);
    wait_fs("lzb_zero");
    capture();
    for (int c = 0; c < 32; c++) begin
      checks++;
      if (an_q[c] !== exp_an(c, 4'b1110) || nib_q[c] !== 4'h0) begin
        failures++;
        $display("FAIL lzb_zero c=%0d an=%b/%b nib=%h/0", c, an_q[c], exp_an(c, 4'b1110), nib_q[c]);
      end
    end
  endtask

  task automatic test_last_wins();
    lzb_en = 0;
    strobe(16'hAAAA);
    repeat (4) @(negedge clk);
    strobe(16'hBBBB);
    checks++;
    if (nibble !== 4'h0) begin
      failures++;
      $display("FAIL last_wins_midframe nib=%h want 0", nibble);
    end
    wait_fs("last_wins");
    capture();
    for (int c = 0; c < 32; c++) begin
      checks++;
      if (an_q[c] !== exp_an(c, 4'b0000) || nib_q[c] !== 4'hB) begin
        failures++;
        $display("FAIL last_wins c=%0d an=%b/%b nib=%h/b", c, an_q[c], exp_an(c, 4'b0000), nib_q[c]);
      end
    end
  endtask

  task automatic test_same_cycle();
    repeat (31) @(negedge clk);
    value = 16'hCCCC;
    value_valid = 1;
    @(negedge clk);
    value_valid = 0;
    checks++;
    if (frame_start !== 1'b1 || nibble !== 4'hB) begin
      failures++;
      $display("FAIL same_cycle_edge fs=%b nib=%h want 1/b", frame_start, nibble);
    end
    capture();
    for (int c = 0; c < 32; c++) begin
      checks++;
      if (nib_q[c] !== 4'hB) begin
        failures++;
        $display("FAIL same_cycle_hold c=%0d nib=%h want b", c, nib_q[c]);
      end
    end
    capture();
    for (int c = 0; c < 32; c++) begin
      checks++;
      if (an_q[c] !== exp_an(c, 4'b0000) || nib_q[c] !== 4'hC) begin
        failures++;
        $display("FAIL same_cycle_next c=%0d an=%b/%b nib=%h/c", c, an_q[c], exp_an(c, 4'b0000), nib_q[c]);
      end
    end
  endtask

  task automatic test_digit_en();
    digit_en = 4'b0101;
    wait_fs("digit_en");
    capture();
    for (int c = 0; c < 32; c++) begin
      checks++;
      if (an_q[c] !== exp_an(c, 4'b1010) || nib_q[c] !== 4'hC || idx_q[c] !== 2'(c / 8) || fs_q[c] !== (c == 0)) begin
        failures++;
        $display("FAIL digit_en c=%0d an=%b/%b nib=%h idx=%0d fs=%b", c, an_q[c], exp_an(c, 4'b1010), nib_q[c], idx_q[c], fs_q[c]);
      end
    end
    checks++;
    if (fs_q[32] !== 1'b1) begin
      failures++;
      $display("FAIL digit_en_period frame_start at +32 = %b want 1", fs_q[32]);
    end
    digit_en = 4'hF;
  endtask

  task automatic test_mid_reset();
    repeat (20) @(negedge clk);
    checks++;
    if (seg_an !== 4'b1011 || nibble !== 4'hC || digit_idx !== 2'd2) begin
      failures++;
      $display("FAIL mid_reset_pre an=%b nib=%h idx=%0d want 1011/c/2", seg_an, nibble, digit_idx);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (seg_an !== 4'hF || nibble !== 4'h0 || digit_idx !== 2'd0 || frame_start !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_async an=%b nib=%h idx=%0d fs=%b want 1111/0/0/0", seg_an, nibble, digit_idx, frame_start);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    capture();
    for (int c = 0; c < 32; c++) begin
      checks++;
      if (an_q[c] !== exp_an(c, 4'b0000) || nib_q[c] !== 4'h0 || idx_q[c] !== 2'(c / 8) || fs_q[c] !== (c == 0)) begin
        failures++;
        $display("FAIL mid_reset_restart c=%0d an=%b/%b nib=%h idx=%0d fs=%b", c, an_q[c], exp_an(c, 4'b0000), nib_q[c], idx_q[c], fs_q[c]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lzb_00a0();
    test_lzb_zero();
    test_last_wins();
    test_same_cycle();
    test_digit_en();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
